// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: double-buffered duty samples, one shared edge/center-aligned counter.
// Optional macro PWM_PHASE_STAGGER_EN offsets each channel's edge-mode compare by k*2^WIDTH/CHANNELS.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         enable,
    input  logic                         center_mode,
    input  logic [CHANNELS*WIDTH-1:0]    sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;

    localparam logic [WIDTH-1:0] MAX = '1;
`ifdef PWM_PHASE_STAGGER_EN
    localparam int STEP = (2 ** WIDTH) / CHANNELS;
`endif

    logic [WIDTH-1:0]          cnt_q,       cnt_d;
    dir_e                      dir_q,       dir_d;
    mode_e                     mode_q,      mode_d;
    logic                      pend_full_q, pend_full_d;
    logic [CHANNELS*WIDTH-1:0] pend_q,      pend_d;
    logic [CHANNELS*WIDTH-1:0] duty_q,      duty_d;
    logic [CHANNELS-1:0]       pwm_q,       pwm_d;
    logic                      pstart_q,    pstart_d;
    logic                      en_q,        en_d;

    logic                      boundary;
    logic                      load;
    logic                      accept;
    logic [WIDTH-1:0]          cmp;

    assign sample_ready = !pend_full_q;
    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        duty_d      = duty_q;
        pwm_d       = '0;
        cmp         = cnt_q;

        boundary = enable &&
                   (((mode_q == MODE_EDGE) && (cnt_q == MAX)) ||
                    ((mode_q == MODE_CENTER) && (dir_q == DIR_DOWN) && (cnt_q == '0)));
        // Idle cycles behave like a permanent boundary for buffer and mode updates.
        load     = boundary || !enable;
        accept   = sample_valid && !pend_full_q;

        if (!enable || boundary) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_q == MODE_EDGE) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
            // The top value is held for one extra cycle while the direction flips.
            if (cnt_q == MAX) dir_d = DIR_DOWN;
            else              cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        if (load) begin
            mode_d = center_mode ? MODE_CENTER : MODE_EDGE;
            if (pend_full_q) begin
                duty_d      = pend_q;
                pend_full_d = 1'b0;
            end
        end

        // Accept and transfer are mutually exclusive: accept needs an empty buffer, transfer a full one.
        if (accept) begin
            pend_d      = sample_in;
            pend_full_d = 1'b1;
        end

        for (int k = 0; k < CHANNELS; k++) begin
            cmp = cnt_q;
`ifdef PWM_PHASE_STAGGER_EN
            if (mode_q == MODE_EDGE) cmp = cnt_q + WIDTH'(k * STEP);
`endif
            pwm_d[k] = enable && (cmp < duty_q[k*WIDTH +: WIDTH]);
        end

        pstart_d = enable && (boundary || !en_q);
        en_d     = enable;
    end

    // NOTE: sequential state uses non-blocking assignments only; duty and pending buffers are
    // plain registers here, so they are reset with everything else.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            mode_q      <= MODE_EDGE;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            duty_q      <= '0;
            pwm_q       <= '0;
            pstart_q    <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
            en_q        <= en_d;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (WIDTH=4, CHANNELS=2): whole-period waveforms compared
// against patterns derived arithmetically from the duty/mode rules.
module tb_pwm_multi;

    localparam int W  = 4;
    localparam int CH = 2;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              enable;
    logic              center_mode;
    logic [CH*W-1:0]   sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [CH-1:0]     pwm_out;
    logic              period_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .center_mode  (center_mode),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output of channel k when the counter is at phase i of its period.
    function automatic bit exp_bit(input int k, input int d, input bit center, input int i);
        int c;
        if (center) begin
            c = (i < 16) ? i : 31 - i;
        end else begin
            c = i;
`ifdef PWM_PHASE_STAGGER_EN
            c = (i + k * (16 / CH)) % 16;
`endif
        end
        return c < d;
    endfunction

    // Starts at the negedge of a cycle whose counter is 0; records one full period of outputs.
    task automatic measure(input string tag, input int d0, input int d1, input bit center,
                           input bit rise, input int send_off, input logic [7:0] send_w,
                           input logic [7:0] junk_w, input int cm_off, input bit cm_val);
        int L = center ? 32 : 16;
        logic [31:0] act0 = '0, act1 = '0, exp0 = '0, exp1 = '0, act_ps = '0, exp_ps = '0;
        for (int j = 1; j <= L; j++) begin
            @(negedge clk);
            act0[j-1]   = pwm_out[0];
            act1[j-1]   = pwm_out[1];
            act_ps[j-1] = period_start;
            exp0[j-1]   = exp_bit(0, d0, center, j - 1);
            exp1[j-1]   = exp_bit(1, d1, center, j - 1);
            exp_ps[j-1] = (j == L) || (rise && j == 1);
            if (j == send_off + 1) check({tag, "_ready_low"}, sample_ready, 1'b0);
            sample_valid = 1'b0;
            if (j == send_off) begin
                sample_valid = 1'b1;
                sample_in    = send_w;
            end
            if (j == send_off + 1) begin
                sample_valid = 1'b1;
                sample_in    = junk_w;
            end
            if (j == cm_off) center_mode = cm_val;
        end
        sample_valid = 1'b0;
        check({tag, "_ch0"}, act0, exp0);
        check({tag, "_ch1"}, act1, exp1);
        check({tag, "_pstart"}, act_ps, exp_ps);
        check({tag, "_ready_end"}, sample_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, p1, d0, d1, off;
        logic [7:0] idle_obs;

        n_rst        = 1'b0;
        enable       = 1'b1;
        center_mode  = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;

        @(negedge clk);
        check("reset_pwm", pwm_out, 2'b00);
        check("reset_pstart", period_start, 1'b0);
        check("reset_ready", sample_ready, 1'b1);

        // Test 1: release reset with {ch1=4, ch0=10} offered in the first cycle.
        @(negedge clk);
        n_rst        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = {4'd4, 4'd10};
        measure("t1_first", 0, 0, 1'b0, 1'b1, -10, 8'h00, 8'h00, -1, 1'b0);

        // Test 2: mid-period sample {ch1=2, ch0=7} plus an ignored second valid.
        measure("t2_old", 10, 4, 1'b0, 1'b0, 3, {4'd2, 4'd7}, {4'd13, 4'd1}, -1, 1'b0);
        p0 = 7;
        p1 = 2;

        for (int i = 0; i < 4; i++) begin
            d0  = int'($urandom_range(0, 15));
            d1  = int'($urandom_range(0, 15));
            off = int'($urandom_range(1, 10));
            measure($sformatf("rnd%0d", i), p0, p1, 1'b0, 1'b0, off,
                    {d1[3:0], d0[3:0]}, 8'($urandom), -1, 1'b0);
            p0 = d0;
            p1 = d1;
        end

        // Test 4: extremes ch0=15, ch1=0.
        measure("t4_load", p0, p1, 1'b0, 1'b0, 2, {4'd0, 4'd15}, 8'h55, -1, 1'b0);
        // center_mode raised mid-period; this period must stay edge-aligned.
        measure("t4_extreme", 15, 0, 1'b0, 1'b0, 2, {4'd3, 4'd3}, 8'hA5, 5, 1'b1);

        // Test 3: center-aligned duty 3, toggled back mid-period.
        measure("t3_center", 3, 3, 1'b1, 1'b0, -10, 8'h00, 8'h00, 10, 1'b0);
        measure("t3_edge_again", 3, 3, 1'b0, 1'b0, -10, 8'h00, 8'h00, -1, 1'b0);

        // Test 5: abort mid-period, load while idle, restart.
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_idle_pwm", pwm_out, 2'b00);
        check("t5_idle_pstart", period_start, 1'b0);
        sample_valid = 1'b1;
        sample_in    = {4'd5, 4'd9};
        @(negedge clk);
        sample_valid = 1'b0;
        check("t5_idle_accept", sample_ready, 1'b0);
        @(negedge clk);
        check("t5_idle_transfer", sample_ready, 1'b1);
        idle_obs = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            idle_obs = idle_obs | {5'd0, period_start, pwm_out};
        end
        check("t5_idle_quiet", idle_obs, 8'h00);
        enable = 1'b1;
        measure("t5_rise", 9, 5, 1'b0, 1'b1, -10, 8'h00, 8'h00, -1, 1'b0);

        // Test 6: async reset mid-period with a pending sample.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = {4'd12, 4'd12};
        @(negedge clk);
        sample_valid = 1'b0;
        check("t6_pending", sample_ready, 1'b0);
        check("t6_pwm_before", pwm_out, {exp_bit(1, 5, 1'b0, 1), exp_bit(0, 9, 1'b0, 1)});
        n_rst = 1'b0;
        #1;
        check("t6_rst_pwm", pwm_out, 2'b00);
        check("t6_rst_pstart", period_start, 1'b0);
        check("t6_rst_ready", sample_ready, 1'b1);
        @(negedge clk);
        n_rst = 1'b1;
        measure("t6_after", 0, 0, 1'b0, 1'b1, -10, 8'h00, 8'h00, -1, 1'b0);
        measure("t6_lost", 0, 0, 1'b0, 1'b0, -10, 8'h00, 8'h00, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised, multi-channel successor to the single-channel 8-bit PWM generator.
- Takes CHANNELS duty samples from the signal mixer through a valid/ready handshake and double-buffers them.
- Shared counter drives CHANNELS registered PWM outputs; edge-aligned or center-aligned mode.
- Duty and mode updates take effect only at period boundaries, so no glitched periods.

Parameters:
- WIDTH, 8, bits per duty sample and counter width; MAX = 2^WIDTH-1.
- CHANNELS, 2, number of independent PWM outputs sharing one counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- enable  in  1  run counter/outputs; low = idle
- center_mode  in  1  0 edge-aligned, 1 center-aligned; sampled at period boundary
- sample_in  in  CHANNELS*WIDTH  duty per channel; channel k at bits [k*WIDTH +: WIDTH]
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  pending buffer empty, can accept
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse at first cycle of each period

Behaviour:
- Reset (async, n_rst=0):
  - counter=0, direction=up, active mode=edge, pending empty.
  - All duty registers 0, pwm_out=0, period_start=0, sample_ready=1.
- Handshake:
  - Accept when sample_valid && sample_ready; the whole CHANNELS-wide word goes into the pending buffer.
  - sample_ready = !pending_full, combinational from the register.
  - Holding sample_valid while ready=0 has no effect.
- Period boundary = last cycle of a period (see modes) while enable=1. On that cycle:
  - If pending is full, copy it to the active duty registers and clear pending.
  - Latch center_mode into the active mode.
- Same-cycle accept at a boundary with pending empty: the sample enters pending and transfers at the next boundary, or while idle (no bypass).
- Edge mode:
  - Counter 0..MAX, then wraps to 0; period 2^WIDTH cycles.
  - Boundary is counter==MAX.
- Center mode:
  - Counter counts up 0..MAX, holds MAX one extra cycle while direction flips to down, then counts MAX..0; period 2^(WIDTH+1) cycles.
  - Boundary is counter==0 with direction=down.
  - Counter 0 repeats at the start of the next up-count.
- Output compare:
  - pwm_out[k] <= enable && (counter < duty[k]), using the counter value of the same cycle; 1-cycle latency.
  - Edge mode: duty d gives d high cycles per period. Center mode: 2d high cycles, symmetric about MAX.
  - duty=0 gives constant 0. Duty never reaches 100%: max is MAX/2^WIDTH.
- period_start: registered; asserted the cycle after a boundary, and the cycle after enable rises.
- enable low (idle):
  - Counter forced to 0, direction=up, pwm_out=0 and period_start=0 next cycle.
  - A full pending buffer transfers to active the next cycle; center_mode is latched every idle cycle.
- enable rise: counting starts from 0 immediately. A fall mid-period aborts the period with no boundary transfer.
- Arithmetic: unsigned compares, counter exactly WIDTH bits, no overflow beyond the wrap defined above.
- Reset mid-period returns everything to reset values asynchronously; the pending sample is lost.

Optional Feature:
- Macro PWM_PHASE_STAGGER_EN.
- Defined:
  - Edge mode: channel k compares against (counter + k*(2^WIDTH/CHANNELS)) mod 2^WIDTH, spreading rising edges across the period to reduce simultaneous switching.
  - Center mode: unchanged.
  - CHANNELS must be a power of two.
- Undefined: all channels compare against the raw counter and rise together on counter 0.

Test Plan:
1. Reset, WIDTH=4, CHANNELS=2, enable=1, edge mode, accept {ch1=4, ch0=10} before the first boundary. Result: from the second period, ch0 is high 10/16 cycles, ch1 high 4/16, both rising on the same cycle; period_start every 16 cycles.
2. Boundary timing: send a new sample mid-period. sample_ready drops the next cycle, the duty changes exactly at the period following period_start, and ready returns to 1 after transfer. A second valid while ready=0 is ignored.
3. Center mode, WIDTH=4, duty=3. pwm_out is high 6 of 32 cycles, centred on the MAX hold; period_start every 32 cycles. Toggling center_mode mid-period changes nothing until the next boundary.
4. Extremes: duty=0 gives pwm_out constantly 0; duty=15 (WIDTH=4) gives 15 high / 1 low per edge period.
5. Drop enable mid-period, load a sample, raise enable. pwm_out=0 while idle, the new duty is active in the first period after the rise, and period_start fires the cycle after the rise.
6. Assert n_rst=0 mid-period with pending full. pwm_out and period_start go to 0 immediately and sample_ready=1. With PWM_PHASE_STAGGER_EN, WIDTH=4, CHANNELS=2: ch1 rises 8 cycles offset from ch0.
